spi_slave_ctrl: RTL

Host-side sequencer for the SPI slave datapath (spi_SlaveMode). It buffers outgoing and incoming bytes in TX and RX FIFOs. It applies mode configuration (slave_mode/cpol/cpha) only between frames. Per byte, it loads the next TX byte into the datapath and collects each received byte. It sits between the host register interface and the slave datapath, entirely in the sys_clk_i domain.

---
 rtl/spi_slave_ctrl_if.sv | 55 +++++
 rtl/spi_slave_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_ctrl_if.sv
// Host and datapath bundle for the SPI slave sequencer.
// master = host/datapath side, slave = the sequencer itself.
interface spi_slave_ctrl_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          cfg_wr;
  logic          cfg_slave_mode;
  logic          cfg_cpol;
  logic          cfg_cpha;
  logic          tx_push;
  logic [7:0]    tx_push_data;
  logic          tx_full;
  logic          rx_pop;
  logic [7:0]    rx_pop_data;
  logic          rx_empty;
  logic [LW-1:0] tx_level;
  logic [LW-1:0] rx_level;
  logic          frame_active;
  logic          frame_done;
  logic [7:0]    frame_bytes;
  logic          underrun;
  logic          overrun;
  logic          clr_status;
  logic          slave_mode;
  logic          cpol;
  logic          cpha;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          rx_byte_valid;
  logic [7:0]    rx_byte;

  modport master (
    output cfg_wr, cfg_slave_mode, cfg_cpol, cfg_cpha,
    output tx_push, tx_push_data, rx_pop, clr_status,
    output rx_byte_valid, rx_byte,
    input  tx_full, rx_pop_data, rx_empty,
    input  tx_level, rx_level,
    input  frame_active, frame_done, frame_bytes,
    input  underrun, overrun,
    input  slave_mode, cpol, cpha, tx_valid, tx_data
  );

  modport slave (
    input  cfg_wr, cfg_slave_mode, cfg_cpol, cfg_cpha,
    input  tx_push, tx_push_data, rx_pop, clr_status,
    input  rx_byte_valid, rx_byte,
    output tx_full, rx_pop_data, rx_empty,
    output tx_level, rx_level,
    output frame_active, frame_done, frame_bytes,
    output underrun, overrun,
    output slave_mode, cpol, cpha, tx_valid, tx_data
  );
endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI slave host sequencer: TX/RX byte FIFOs, frame FSM,
// between-frame mode config and sticky under/overrun status.
module spi_slave_ctrl #(
  parameter int         DEPTH     = 8,
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input logic             sys_clk_i,
  input logic             sys_rstn_i,
  input logic             ssn_i,
  spi_slave_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ACTIVE,
    S_END
  } state_e;

  state_e        state_q, state_d;
  logic          ssn_m_q, ssn_s_q;
  logic          rxv_q;
  logic          mode_q, mode_d;
  logic          cpol_q, cpol_d;
  logic          cpha_q, cpha_d;
  logic          pend_q, pend_d;
  logic [2:0]    pcfg_q, pcfg_d;
  logic [7:0]    tx_mem_q [DEPTH];
  logic [7:0]    rx_mem_q [DEPTH];
  logic [LW-1:0] tx_wp_q, tx_wp_d;
  logic [LW-1:0] tx_rp_q, tx_rp_d;
  logic [LW-1:0] rx_wp_q, rx_wp_d;
  logic [LW-1:0] rx_rp_q, rx_rp_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          fa_q, fa_d;
  logic          fd_q, fd_d;
  logic [7:0]    fb_q, fb_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          ur_q, ur_d;
  logic          ov_q, ov_d;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic byte_ev, load, tx_pop, tx_we;
  logic rx_push, rx_we;

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign tx_full  = (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]) &&
                    (tx_wp_q[AW] != tx_rp_q[AW]);
  assign rx_full  = (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]) &&
                    (rx_wp_q[AW] != rx_rp_q[AW]);
  assign byte_ev  = (state_q == S_ACTIVE) &&
                    bus.rx_byte_valid && !rxv_q;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    pend_d     = pend_q;
    pcfg_d     = pcfg_q;
    tx_wp_d    = tx_wp_q;
    tx_rp_d    = tx_rp_q;
    rx_wp_d    = rx_wp_q;
    rx_rp_d    = rx_rp_q;
    tx_valid_d = 1'b0;
    tx_data_d  = tx_data_q;
    fd_d       = 1'b0;
    fb_d       = fb_q;
    cnt_d      = cnt_q;
    ur_d       = ur_q;
    ov_d       = ov_q;
    load       = 1'b0;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    if (bus.clr_status) begin
      ur_d = 1'b0;
      ov_d = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        if (bus.cfg_wr) begin
          mode_d = bus.cfg_slave_mode;
          cpol_d = bus.cfg_cpol;
          cpha_d = bus.cfg_cpha;
        end
        if (!ssn_s_q && mode_q) begin
          state_d = S_LOAD;
          load    = 1'b1;
        end
      end
      S_LOAD: state_d = S_ACTIVE;
      S_ACTIVE: begin
        if (byte_ev) begin
          rx_push = 1'b1;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          // no point preloading a byte for a frame that is ending
          load = !ssn_s_q;
        end
        if (ssn_s_q) begin
          state_d = S_END;
          fd_d    = 1'b1;
          fb_d    = cnt_d;
          cnt_d   = '0;
        end
      end
      S_END: begin
        state_d = S_IDLE;
        if (bus.cfg_wr) begin
          mode_d = bus.cfg_slave_mode;
          cpol_d = bus.cfg_cpol;
          cpha_d = bus.cfg_cpha;
        end else if (pend_q) begin
          {mode_d, cpol_d, cpha_d} = pcfg_q;
        end
        pend_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.cfg_wr &&
        (state_q == S_LOAD || state_q == S_ACTIVE)) begin
      pend_d = 1'b1;
      pcfg_d = {bus.cfg_slave_mode, bus.cfg_cpol, bus.cfg_cpha};
    end
    if (load) begin
      tx_valid_d = 1'b1;
      if (!tx_empty) begin
        tx_pop    = 1'b1;
        tx_data_d = tx_mem_q[tx_rp_q[AW-1:0]];
      end else begin
        tx_data_d = FILL_BYTE;
        ur_d      = 1'b1;
      end
    end
    tx_we = bus.tx_push && !tx_full;
    if (tx_we)  tx_wp_d = tx_wp_q + 1'b1;
    if (tx_pop) tx_rp_d = tx_rp_q + 1'b1;
    rx_we = rx_push && !rx_full;
    if (rx_push && rx_full) ov_d = 1'b1;
    if (rx_we) rx_wp_d = rx_wp_q + 1'b1;
    if (bus.rx_pop && !rx_empty) rx_rp_d = rx_rp_q + 1'b1;
    fa_d = (state_d == S_ACTIVE);
  end

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state_q    <= S_IDLE;
      ssn_m_q    <= 1'b1;
      ssn_s_q    <= 1'b1;
      rxv_q      <= 1'b0;
      mode_q     <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      pend_q     <= 1'b0;
      pcfg_q     <= '0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      fa_q       <= 1'b0;
      fd_q       <= 1'b0;
      fb_q       <= '0;
      cnt_q      <= '0;
      ur_q       <= 1'b0;
      ov_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ssn_m_q    <= ssn_i;
      ssn_s_q    <= ssn_m_q;
      rxv_q      <= bus.rx_byte_valid;
      mode_q     <= mode_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      pend_q     <= pend_d;
      pcfg_q     <= pcfg_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      fa_q       <= fa_d;
      fd_q       <= fd_d;
      fb_q       <= fb_d;
      cnt_q      <= cnt_d;
      ur_q       <= ur_d;
      ov_q       <= ov_d;
      if (tx_we) tx_mem_q[tx_wp_q[AW-1:0]] <= bus.tx_push_data;
      if (rx_we) rx_mem_q[rx_wp_q[AW-1:0]] <= bus.rx_byte;
    end
  end

  assign bus.tx_full      = tx_full;
  assign bus.rx_empty     = rx_empty;
  assign bus.rx_pop_data  = rx_mem_q[rx_rp_q[AW-1:0]];
  assign bus.tx_level     = tx_wp_q - tx_rp_q;
  assign bus.rx_level     = rx_wp_q - rx_rp_q;
  assign bus.frame_active = fa_q;
  assign bus.frame_done   = fd_q;
  assign bus.frame_bytes  = fb_q;
  assign bus.underrun     = ur_q;
  assign bus.overrun      = ov_q;
  assign bus.slave_mode   = mode_q;
  assign bus.cpol         = cpol_q;
  assign bus.cpha         = cpha_q;
  assign bus.tx_valid     = tx_valid_q;
  assign bus.tx_data      = tx_data_q;
endmodule
